gpio_in_debounce: RTL and testbench

- Input-conditioning stage that sits directly upstream of the core's gpio_in port. It converts raw, asynchronous pad inputs into clean, synchronised, debounced levels for the core.
- Alongside the levels it produces per-bit rise/fall pulses and sticky event flags, which a later MMIO/IRQ layer consumes.
- One instance per tile; all state is in the clk domain.

---
 rtl/gpio_in_debounce.sv | 59 +++++
 tb/tb_gpio_in_debounce.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: synchronise, debounce and edge-detect raw pad inputs for the core gpio_in port.
module gpio_in_debounce #(
  parameter int WIDTH = 8,
  parameter int DEB_COUNT = 4,
  parameter int PRESCALE = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt_sticky,
  output logic             evt_any
);
  localparam int CW = DEB_COUNT > 1 ? $clog2(DEB_COUNT) : 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_COUNT - 1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [WIDTH-1:0] s1, s2, flip, sticky_n;
  logic [PW-1:0] pcnt;
  logic [CW-1:0] cnt [WIDTH];
  logic [CW-1:0] cnt_n [WIDTH];
  logic tick;
  assign tick = pcnt == PMAX;
  // a bit flips once DEB_COUNT consecutive ticks have seen it differ from the accepted level
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = tick && s2[i] != gpio_in[i] && cnt[i] == CMAX;
      cnt_n[i] = !tick ? cnt[i] : (s2[i] == gpio_in[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
    end
    sticky_n = (evt_sticky & ~evt_clr) | flip;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      pcnt <= '0;
      gpio_in <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      evt_sticky <= '0;
      evt_any <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1 <= pad_in;
      s2 <= s1;
      pcnt <= tick ? '0 : pcnt + 1'b1;
      gpio_in <= gpio_in ^ flip;
      rise <= flip & ~gpio_in;
      fall <= flip & gpio_in;
      evt_sticky <= sticky_n;
      evt_any <= |sticky_n;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_n[i];
    end
  end
endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce: directed and random checks of gpio_in_debounce against a sliding-window reference model.
module tb_gpio_in_debounce;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] pad = 8'hA5, clr = 8'h00, pad2 = 8'h00;
  logic [7:0] gpio, rise, fall, sticky, gpio2, rise2, fall2, sticky2;
  logic any, any2;
  int ncmp = 0, nfail = 0, ecount = 0;
  logic [7:0] m_sync [2];
  logic [7:0] m_win [$];
  logic [7:0] m_gpio, m_rise, m_fall, m_sticky;
  logic m_any;
  always #5 clk = ~clk;
  gpio_in_debounce u1 (.clk(clk), .rst_n(rst_n), .pad_in(pad), .evt_clr(clr), .gpio_in(gpio),
    .rise(rise), .fall(fall), .evt_sticky(sticky), .evt_any(any));
  gpio_in_debounce #(.DEB_COUNT(2), .PRESCALE(10)) u2 (.clk(clk), .rst_n(rst_n), .pad_in(pad2),
    .evt_clr(8'h00), .gpio_in(gpio2), .rise(rise2), .fall(fall2), .evt_sticky(sticky2), .evt_any(any2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_sync = '{8'h00, 8'h00};
    m_win.delete();
    m_gpio = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_sticky = 8'h00; m_any = 1'b0;
    ecount = 0;
  endtask
  // a level is accepted when the last D synchronised samples all differ from the current level
  task automatic step();
    logic [7:0] pv, cv, s2b, fl;
    pv = pad; cv = clr;
    @(posedge clk); #1;
    ecount++;
    s2b = m_sync[1]; m_sync[1] = m_sync[0]; m_sync[0] = pv;
    m_win.push_back(s2b);
    if (m_win.size() > D) void'(m_win.pop_front());
    fl = 8'h00;
    if (m_win.size() == D)
      for (int b = 0; b < 8; b++) begin
        fl[b] = 1'b1;
        for (int k = 0; k < m_win.size(); k++) if (m_win[k][b] == m_gpio[b]) fl[b] = 1'b0;
      end
    m_rise = fl & ~m_gpio;
    m_fall = fl & m_gpio;
    m_gpio = m_gpio ^ fl;
    m_sticky = (m_sticky & ~cv) | fl;
    m_any = |m_sticky;
    chk("gpio_in", gpio, m_gpio);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("evt_sticky", sticky, m_sticky);
    chk("evt_any", any, m_any);
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gpio", gpio, 8'h00);
    chk("arst_sticky", sticky, 8'h00);
    chk("arst_any", any, 1'b0);
    chk("arst_rise", rise | fall, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    int n, k0, t1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio", gpio, 8'h00);
    chk("rst_sticky", sticky, 8'h00);
    rst_n = 1'b1;
    model_reset();
    repeat (5) step();
    chk("lat_before", gpio, 8'h00);
    step();
    chk("lat_gpio", gpio, 8'hA5);
    chk("lat_rise", rise, 8'hA5);
    chk("lat_sticky", sticky, 8'hA5);
    chk("lat_any", any, 1'b1);
    step();
    chk("rise_once", rise, 8'h00);
    clr = 8'hFF; step(); clr = 8'h00;
    pad = 8'hA1;
    repeat (6) step();
    chk("fall2", fall, 8'h04);
    chk("fall_sticky", sticky, 8'h04);
    clr = 8'h04; step(); clr = 8'h00;
    chk("clr_sticky", sticky, 8'h00);
    chk("clr_any", any, 1'b0);
    pad = 8'h00;
    repeat (8) step();
    clr = 8'hFF; step(); clr = 8'h00;
    pad = 8'h01; repeat (3) step(); pad = 8'h00;
    repeat (8) step();
    chk("glitch3", gpio[0], 1'b0);
    pad = 8'h01; repeat (4) step(); pad = 8'h00;
    repeat (2) step();
    chk("pulse4_gpio", gpio[0], 1'b1);
    chk("pulse4_rise", rise[0], 1'b1);
    repeat (8) step();
    pad = 8'h08;
    repeat (5) step();
    clr = 8'h08; step(); clr = 8'h00;
    chk("coll_rise", rise[3], 1'b1);
    chk("coll_sticky", sticky[3], 1'b1);
    repeat (1500) begin
      if ($urandom % 8 == 0) pad = pad ^ 8'($urandom);
      clr = ($urandom % 4 == 0) ? 8'($urandom) : 8'h00;
      step();
    end
    clr = 8'hFF; pad = 8'h00;
    repeat (10) step();
    clr = 8'h00;
    pad = 8'h10; repeat (8) step();
    pad = 8'h12; repeat (4) step();
    chk("pre_arst_sticky", sticky, 8'h10);
    async_reset();
    repeat (5) step();
    chk("arst_restart_hold", gpio, 8'h00);
    step();
    chk("arst_restart_gpio", gpio, 8'h12);
    chk("arst_restart_rise", rise, 8'h12);
    repeat ($urandom % 10) step();
    k0 = ecount;
    pad2[7] = 1'b1;
    n = 0;
    while (gpio2[7] !== 1'b1 && n < 40) begin step(); n++; end
    t1 = k0 + 2;
    while (t1 % 10 != 9) t1++;
    chk("pre_latency", n, t1 + 10 - k0 + 1);
    chk("pre_range", (n >= 11 && n <= 22), 1'b1);
    chk("pre_rise", rise2[7], 1'b1);
    while (ecount % 10 != 0) step();
    pad2[6] = 1'b1; repeat (3) step(); pad2[6] = 1'b0;
    repeat (30) step();
    chk("pre_toggle_gpio", gpio2[6], 1'b0);
    chk("pre_toggle_sticky", sticky2[6], 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
